// File: rtl/avalon_led_pwm_pkg.sv
// Shared register map and field widths for the Avalon-MM LED PWM port.
package avalon_led_pwm_pkg;

    localparam logic [3:0] DATA       = 4'd0;
    localparam logic [3:0] SET        = 4'd1;
    localparam logic [3:0] CLR        = 4'd2;
    localparam logic [3:0] PRESCALE   = 4'd3;
    localparam logic [3:0] BLINK      = 4'd4;
    localparam logic [3:0] BLINK_HALF = 4'd5;
    localparam logic [3:0] DUTY_BASE  = 4'd8;

    localparam int unsigned PRESCALE_W   = 16;
    localparam int unsigned BLINK_HALF_W = 16;

endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaled tick, free-running PWM frame counter and shared blink phase generator.
module led_pwm_timebase
    import avalon_led_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [BLINK_HALF_W-1:0] blink_half,
    input  logic                    clr_pcnt,
    input  logic                    clr_blink,
    output logic [PWM_BITS-1:0]     pwm,
    output logic                    phase
);

    localparam logic [PWM_BITS-1:0]     PwmOne   = PWM_BITS'(1);
    localparam logic [PRESCALE_W-1:0]   PcntOne  = PRESCALE_W'(1);
    localparam logic [BLINK_HALF_W-1:0] BcntOne  = BLINK_HALF_W'(1);

    logic [PRESCALE_W-1:0]   pcnt_q, pcnt_d;
    logic [PWM_BITS-1:0]     pwm_q, pwm_d;
    logic [BLINK_HALF_W-1:0] bcnt_q, bcnt_d;
    logic                    phase_q, phase_d;
    logic                    tick;
    logic                    frame_end;

    always_comb begin
        // >= rather than == so lowering PRESCALE below pcnt ticks at once
        tick      = (pcnt_q >= prescale);
        frame_end = tick && (pwm_q == '1);

        pcnt_d = tick ? '0 : pcnt_q + PcntOne;
        if (clr_pcnt) begin
            pcnt_d = '0;
        end

        pwm_d = tick ? pwm_q + PwmOne : pwm_q;

        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (clr_blink) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (frame_end && (blink_half != '0)) begin
            if (bcnt_q == blink_half - BcntOne) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BcntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q  <= '0;
            pwm_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            pcnt_q  <= pcnt_d;
            pwm_q   <= pwm_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign pwm   = pwm_q;
    assign phase = phase_q;

endmodule

// File: rtl/avalon_led_pwm.sv
// Avalon-MM LED port: enable bits with set/clear, per-channel PWM duty and masked blink.
module avalon_led_pwm
    import avalon_led_pwm_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]        data_q;
    logic [WIDTH-1:0]        blink_q;
    logic [PRESCALE_W-1:0]   prescale_q;
    logic [BLINK_HALF_W-1:0] blink_half_q;
    logic [PWM_BITS-1:0]     duty_q [WIDTH];

    logic                    wr;
    logic [WIDTH-1:0]        duty_we;
    logic [PWM_BITS-1:0]     pwm;
    logic                    phase;
    logic [WIDTH-1:0]        pwm_on;
    logic [WIDTH-1:0]        out_d;

    assign wr = chipselect && !write_n;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            duty_we[i] = wr && address[3] && (address[2:0] == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q       <= '0;
            blink_q      <= '0;
            prescale_q   <= '0;
            blink_half_q <= '0;
        end else if (wr) begin
            case (address)
                DATA:       data_q       <= writedata[WIDTH-1:0];
                SET:        data_q       <= data_q | writedata[WIDTH-1:0];
                CLR:        data_q       <= data_q & ~writedata[WIDTH-1:0];
                PRESCALE:   prescale_q   <= writedata[PRESCALE_W-1:0];
                BLINK:      blink_q      <= writedata[WIDTH-1:0];
                BLINK_HALF: blink_half_q <= writedata[BLINK_HALF_W-1:0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                duty_q[i] <= '1;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (duty_we[i]) begin
                    duty_q[i] <= writedata[PWM_BITS-1:0];
                end
            end
        end
    end

    // SET and CLR are write-only strobes; reading them shows the live DATA value
    always_comb begin
        readdata = '0;
        case (address)
            DATA, SET, CLR: readdata = 32'(data_q);
            PRESCALE:       readdata = 32'(prescale_q);
            BLINK:          readdata = 32'(blink_q);
            BLINK_HALF:     readdata = 32'(blink_half_q);
            default: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (address[3] && (address[2:0] == 3'(i))) begin
                        readdata = 32'(duty_q[i]);
                    end
                end
            end
        endcase
    end

    led_pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk        (clk),
        .reset_n    (reset_n),
        .prescale   (prescale_q),
        .blink_half (blink_half_q),
        .clr_pcnt   (wr && (address == PRESCALE)),
        .clr_blink  (wr && (address == BLINK_HALF)),
        .pwm        (pwm),
        .phase      (phase)
    );

    // All-ones duty is forced on so a full-duty channel never shows a one-tick gap
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pwm_on[i] = (duty_q[i] == '1) || (pwm < duty_q[i]);
        end
        out_d = data_q & pwm_on & (~blink_q | {WIDTH{phase}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= '0;
        end else begin
            out_port <= out_d;
        end
    end

endmodule
